mult_job_sequencer: RTL and testbench

MULT_JOB_SEQUENCER -- requirements
Module: mult_job_sequencer

---
 rtl/mult_seq_pkg.sv | 17 +
 rtl/mult_seq_timeout_ctr.sv | 28 ++
 rtl/mult_job_sequencer.sv | 147 ++++++++++++++
 tb/tb_mult_job_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_seq_pkg.sv
// Shared types and sizes for the multiplier job sequencer.
// Holds the FSM state enum, the operand/result widths and the default abort limit.
package mult_seq_pkg;

    localparam int OPW             = 4;
    localparam int RESW            = 8;
    localparam int CNTW            = 8;
    localparam int TIMEOUT_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_e;

endpackage

// File: rtl/mult_seq_timeout_ctr.sv
// Clearable 8-bit WAIT-cycle counter for the job sequencer.
// tc_o flags the cycle that is the TIMEOUT_CYCLES-th consecutive enabled cycle since the clear.
module mult_seq_timeout_ctr
    import mult_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CNTW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    // The count holds completed cycles, so the limit cycle is the one where it equals limit-1.
    assign tc_o = (count_q == CNTW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mult_job_sequencer.sv
// Sequences one operand job at a time through an external shift-add multiplier,
// with a WAIT-state timeout, a held result for the consumer and a success counter.
module mult_job_sequencer
    import mult_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  in_a,
    input  logic [OPW-1:0]  in_b,
    output logic [OPW-1:0]  mul_a,
    output logic [OPW-1:0]  mul_b,
    output logic            mul_start,
    input  logic            mul_done,
    input  logic [RESW-1:0] mul_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [RESW-1:0] out_data,
    output logic            out_err,
    output logic [7:0]      job_count
);

    state_e          state_q,    state_d;
    logic [OPW-1:0]  opA_q,      opA_d;
    logic [OPW-1:0]  opB_q,      opB_d;
    logic            mulStart_q, mulStart_d;
    logic            outValid_q, outValid_d;
    logic [RESW-1:0] outData_q,  outData_d;
    logic            outErr_q,   outErr_d;
    logic [7:0]      jobCount_q, jobCount_d;
    logic            cntClr;
    logic            cntEn;
    logic            timeoutHit;

    mult_seq_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cntClr),
        .en_i  (cntEn),
        .tc_o  (timeoutHit)
    );

    assign in_ready = !rst && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));

    // The operand registers drive the multiplier buses directly and are zeroed
    // when the job leaves WAIT, so the buses read 0 whenever no job is in flight.
    always_comb begin
        state_d    = state_q;
        opA_d      = opA_q;
        opB_d      = opB_q;
        mulStart_d = mulStart_q;
        outValid_d = outValid_q;
        outData_d  = outData_q;
        outErr_d   = outErr_q;
        jobCount_d = jobCount_q;
        cntClr     = 1'b0;
        cntEn      = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opA_d      = in_a;
                    opB_d      = in_b;
                    mulStart_d = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                mulStart_d = 1'b0;
                cntClr     = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
                cntEn = 1'b1;
                // Done wins over the timeout when both land on the same cycle.
                if (mul_done) begin
                    outData_d  = mul_result;
                    outErr_d   = 1'b0;
                    outValid_d = 1'b1;
                    jobCount_d = jobCount_q + 8'd1;
                    opA_d      = '0;
                    opB_d      = '0;
                    state_d    = HOLD;
                end else if (timeoutHit) begin
                    outData_d  = '0;
                    outErr_d   = 1'b1;
                    outValid_d = 1'b1;
                    opA_d      = '0;
                    opB_d      = '0;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    outValid_d = 1'b0;
                    if (in_valid) begin
                        opA_d      = in_a;
                        opB_d      = in_b;
                        mulStart_d = 1'b1;
                        state_d    = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            opA_q      <= '0;
            opB_q      <= '0;
            mulStart_q <= 1'b0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outErr_q   <= 1'b0;
            jobCount_q <= '0;
        end else begin
            state_q    <= state_d;
            opA_q      <= opA_d;
            opB_q      <= opB_d;
            mulStart_q <= mulStart_d;
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            outErr_q   <= outErr_d;
            jobCount_q <= jobCount_d;
        end
    end

    assign mul_a     = opA_q;
    assign mul_b     = opB_q;
    assign mul_start = mulStart_q;
    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_err   = outErr_q;
    assign job_count = jobCount_q;

endmodule

// File: tb/tb_mult_job_sequencer.sv
// Self-checking bench for mult_job_sequencer: directed and randomized jobs against a
// job-level reference (expected product, error flag, success count and cycle-by-cycle phases).
module tb_mult_job_sequencer;

    localparam int TO = 32;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [3:0] mul_a;
    logic [3:0] mul_b;
    logic       mul_start;
    logic       mul_done;
    logic [7:0] mul_result;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_err;
    logic [7:0] job_count;

    int checks   = 0;
    int failures = 0;
    int expCount = 0;
    int expData  = 0;
    int expErr   = 0;

    mult_job_sequencer #(
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_start  (mul_start),
        .mul_done   (mul_done),
        .mul_result (mul_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_err    (out_err),
        .job_count  (job_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a job while the block is idle; the acceptance cycle itself must not strobe.
    task automatic acceptFromIdle(input int a, input int b);
        in_valid = 1'b1;
        in_a     = 4'(a);
        in_b     = 4'(b);
        mul_done = 1'($urandom);
        #1;
        checkOutput("in_ready_idle", in_ready, 1);
        checkOutput("mul_a_idle", mul_a, 0);
        checkOutput("mul_start_idle", mul_start, 0);
        checkOutput("out_valid_idle", out_valid, 0);
        step();
        in_valid = 1'b0;
        in_a     = 4'($urandom);
        in_b     = 4'($urandom);
    endtask

    // ISSUE, then WAIT until Done on cycle 'delay' (0 = never), then 'stall' backpressured HOLD cycles.
    task automatic applyStimulus(input int a, input int b, input int delay, input int stall);
        int  n;
        bit  hit;
        mul_done   = 1'($urandom);
        mul_result = 8'($urandom);
        #1;
        checkOutput("issue_start", mul_start, 1);
        checkOutput("issue_mul_a", mul_a, a);
        checkOutput("issue_mul_b", mul_b, b);
        checkOutput("issue_in_ready", in_ready, 0);
        checkOutput("issue_out_valid", out_valid, 0);
        step();
        n = 0;
        forever begin
            n++;
            hit        = (delay != 0) && (n == delay);
            mul_done   = hit;
            mul_result = hit ? 8'(a * b) : 8'($urandom);
            in_valid   = 1'($urandom);
            out_ready  = 1'($urandom);
            #1;
            checkOutput("wait_start", mul_start, 0);
            checkOutput("wait_mul_a", mul_a, a);
            checkOutput("wait_mul_b", mul_b, b);
            checkOutput("wait_in_ready", in_ready, 0);
            checkOutput("wait_out_valid", out_valid, 0);
            step();
            if (hit || n == TO) break;
        end
        in_valid = 1'b0;
        if (hit) begin
            expData  = a * b;
            expErr   = 0;
            expCount = (expCount + 1) % 256;
        end else begin
            expData = 0;
            expErr  = 1;
        end
        for (int s = 0; s < stall; s++) begin
            out_ready  = 1'b0;
            in_valid   = 1'b1;
            in_a       = 4'($urandom);
            mul_done   = 1'($urandom);
            mul_result = 8'($urandom);
            #1;
            checkOutput("hold_out_valid", out_valid, 1);
            checkOutput("hold_out_data", out_data, expData);
            checkOutput("hold_out_err", out_err, expErr);
            checkOutput("hold_job_count", job_count, expCount);
            checkOutput("hold_in_ready", in_ready, 0);
            checkOutput("hold_mul_start", mul_start, 0);
            step();
        end
        in_valid = 1'b0;
        mul_done = 1'b0;
    endtask

    task automatic releaseToIdle();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        #1;
        checkOutput("rel_out_valid", out_valid, 1);
        checkOutput("rel_out_data", out_data, expData);
        checkOutput("rel_out_err", out_err, expErr);
        checkOutput("rel_job_count", job_count, expCount);
        checkOutput("rel_in_ready", in_ready, 1);
        step();
        out_ready = 1'b0;
        #1;
        checkOutput("idle_out_valid", out_valid, 0);
        checkOutput("idle_in_ready", in_ready, 1);
    endtask

    task automatic acceptFromHold(input int a, input int b);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = 4'(a);
        in_b      = 4'(b);
        #1;
        checkOutput("b2b_out_valid", out_valid, 1);
        checkOutput("b2b_out_data", out_data, expData);
        checkOutput("b2b_out_err", out_err, expErr);
        checkOutput("b2b_in_ready", in_ready, 1);
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    initial begin
        int a;
        int b;
        int na;
        int nb;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        mul_done   = 1'b0;
        mul_result = '0;
        out_ready  = 1'b0;
        step();
        step();
        #1;
        checkOutput("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", in_ready, 1);
        checkOutput("post_rst_out_valid", out_valid, 0);
        checkOutput("post_rst_job_count", job_count, 0);
        checkOutput("post_rst_mul_start", mul_start, 0);
        checkOutput("post_rst_mul_a", mul_a, 0);

        $display("[TB] basic product 3x5");
        acceptFromIdle(3, 5);
        applyStimulus(3, 5, 10, 0);
        releaseToIdle();

        $display("[TB] max product then zero operand");
        acceptFromIdle(15, 15);
        applyStimulus(15, 15, 4, 1);
        releaseToIdle();
        acceptFromIdle(0, 9);
        applyStimulus(0, 9, 2, 0);
        releaseToIdle();

        $display("[TB] backpressure");
        acceptFromIdle(6, 11);
        applyStimulus(6, 11, 3, 5);
        releaseToIdle();

        $display("[TB] back-to-back");
        acceptFromIdle(2, 7);
        applyStimulus(2, 7, 5, 0);
        acceptFromHold(4, 4);
        applyStimulus(4, 4, 1, 0);
        releaseToIdle();

        $display("[TB] timeout and done on the limit cycle");
        acceptFromIdle(9, 9);
        applyStimulus(9, 9, 0, 2);
        releaseToIdle();
        acceptFromIdle(13, 7);
        applyStimulus(13, 7, TO, 0);
        releaseToIdle();

        $display("[TB] randomized jobs");
        a = $urandom_range(0, 15);
        b = $urandom_range(0, 15);
        acceptFromIdle(a, b);
        for (int i = 0; i < 24; i++) begin
            applyStimulus(a, b, $urandom_range(0, TO), $urandom_range(0, 3));
            na = $urandom_range(0, 15);
            nb = $urandom_range(0, 15);
            if (i < 23 && ($urandom % 2) == 1) begin
                acceptFromHold(na, nb);
            end else begin
                releaseToIdle();
                if (i < 23) acceptFromIdle(na, nb);
            end
            a = na;
            b = nb;
        end

        $display("[TB] reset mid-wait");
        acceptFromIdle(6, 7);
        mul_done = 1'b0;
        step();
        for (int k = 0; k < 3; k++) step();
        rst = 1'b1;
        step();
        #1;
        checkOutput("midrst_in_ready", in_ready, 0);
        rst      = 1'b0;
        mul_done = 1'b1;
        expCount = 0;
        #1;
        checkOutput("midrst_idle_in_ready", in_ready, 1);
        checkOutput("midrst_mul_start", mul_start, 0);
        checkOutput("midrst_mul_a", mul_a, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            #1;
            checkOutput("midrst_out_valid", out_valid, 0);
            checkOutput("midrst_job_count", job_count, 0);
            checkOutput("midrst_mul_start_idle", mul_start, 0);
        end
        mul_done = 1'b0;

        $display("[TB] job_count wrap");
        for (int i = 0; i < 256; i++) begin
            a = $urandom_range(0, 15);
            b = $urandom_range(0, 15);
            acceptFromIdle(a, b);
            applyStimulus(a, b, 1, 0);
            releaseToIdle();
        end
        checkOutput("wrap_job_count", job_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
